// File: rtl/m_regfile_sb.sv
// -----------------------------------------------------------------------------
// m_regfile_sb
//
// Datapath register file with a clear sequencer, per-register pending
// (scoreboard) bits and optional same-cycle write-to-read forwarding.
// Decode reads operands and marks destinations pending. Writeback writes
// results and retires the pending marks.
//
// After reset the sequencer spends NREG-1 cycles (CLEAR) zeroing registers
// 1..NREG-1, one per cycle. It then enters RUN and raises w_ready.
//
// Parameters
//   XLEN    data width in bits
//   NREG    register count (power of two, >= 2)
//   BYPASS  1: same-cycle write data / pending-clear forwarded to read ports
//
// Ports
//   w_clk               clock, all state changes on posedge
//   w_rst               synchronous active-high reset
//   w_rr1, w_rr2        read indices
//   w_rdata1, w_rdata2  read data (combinational)
//   w_pend1, w_pend2    pending status of w_rr1 / w_rr2 (combinational)
//   w_wr, w_we, w_wdata write port
//   w_iss_en, w_iss_rd  mark a destination pending
//   w_ready             high in RUN
// -----------------------------------------------------------------------------
module m_regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic            w_clk,
    input  logic            w_rst,
    input  logic [AW-1:0]   w_rr1,
    input  logic [AW-1:0]   w_rr2,
    output logic [XLEN-1:0] w_rdata1,
    output logic [XLEN-1:0] w_rdata2,
    output logic            w_pend1,
    output logic            w_pend2,
    input  logic [AW-1:0]   w_wr,
    input  logic            w_we,
    input  logic [XLEN-1:0] w_wdata,
    input  logic            w_iss_en,
    input  logic [AW-1:0]   w_iss_rd,
    output logic            w_ready
);

    localparam logic [0:0]    ST_CLEAR = 1'b0;
    localparam logic [0:0]    ST_RUN   = 1'b1;
    localparam logic [AW-1:0] CNT_ONE  = AW'(1);
    localparam logic [AW-1:0] CNT_LAST = AW'(NREG - 1);
    localparam logic          BYP      = (BYPASS != 0);

    logic [0:0]      state_reg;
    logic [0:0]      state_next;
    logic [AW-1:0]   cnt_reg;
    logic [AW-1:0]   cnt_next;
    logic [NREG-1:0] pend_reg;
    logic [NREG-1:0] pend_set;
    logic [NREG-1:0] pend_clr;
    logic            running;

    // Single write port shared by the clear sequencer and writeback.
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] r_mem [NREG];

    assign running = (state_reg == ST_RUN);
    assign w_ready = running;

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (!running) begin
            cnt_next = cnt_reg + CNT_ONE;
            // The cycle that zeroes the last register also enters RUN.
            if (cnt_reg == CNT_LAST) begin
                state_next = ST_RUN;
            end
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state_reg <= ST_CLEAR;
            cnt_reg   <= CNT_ONE;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Register storage. Index 0 is never written: the sequencer starts at 1
    // and writeback to 0 is dropped, and the read path forces 0 anyway.
    // ------------------------------------------------------------------
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = cnt_reg;
        mem_wdata = '0;
        if (!running) begin
            mem_we = 1'b1;
        end else if (!w_rst && w_we && (w_wr != '0)) begin
            mem_we    = 1'b1;
            mem_waddr = w_wr;
            mem_wdata = w_wdata;
        end
    end

    always_ff @(posedge w_clk) begin
        if (mem_we) begin
            r_mem[mem_waddr] <= mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Pending bits. Set has priority over clear, so an issue and a write
    // to the same index on one edge leave the register pending.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
            if (gi == 0) begin : g_zero
                assign pend_set[gi] = 1'b0;
                assign pend_clr[gi] = 1'b0;
            end else begin : g_idx
                assign pend_set[gi] = running & w_iss_en & (w_iss_rd == AW'(gi));
                assign pend_clr[gi] = running & w_we & (w_wr == AW'(gi));
            end
        end
    endgenerate

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            pend_reg <= '0;
        end else begin
            pend_reg <= (pend_reg & ~pend_clr) | pend_set;
        end
    end

    // ------------------------------------------------------------------
    // Read ports. The hit term forwards a same-cycle write, both its data
    // and its pending-clear. Outputs are held at 0 until RUN.
    // ------------------------------------------------------------------
    logic hit1;
    logic hit2;

    assign hit1 = BYP & w_we & (w_wr == w_rr1);
    assign hit2 = BYP & w_we & (w_wr == w_rr2);

    assign w_rdata1 = (!running || (w_rr1 == '0)) ? '0 :
                      hit1 ? w_wdata : r_mem[w_rr1];
    assign w_rdata2 = (!running || (w_rr2 == '0)) ? '0 :
                      hit2 ? w_wdata : r_mem[w_rr2];

    assign w_pend1 = running & pend_reg[w_rr1] & ~hit1;
    assign w_pend2 = running & pend_reg[w_rr2] & ~hit2;

endmodule

// File: doc/m_regfile_sb.md
# m_regfile_sb

Parametrised register file with synchronous-reset clear sequencer, per-register pending (scoreboard) bits, and optional same-cycle write-to-read bypass. It is the next-generation datapath register file for the multi-cycle and pipelined processor labs. It sits between decode, which reads operands and marks destinations pending, and writeback, which writes results and retires pending marks.

## Interface
- XLEN, 32, data width in bits.
- NREG, 32, register count; power of two, ≥2; index width AW = $clog2(NREG).
- BYPASS, 1, 1 forwards same-cycle write data and pending-clear to read ports; 0 disables forwarding.

- w_clk  input  1  clock; all state changes on posedge.
- w_rst  input  1  synchronous, active-high reset.
- w_rr1, w_rr2  input  AW  read indices.
- w_rdata1, w_rdata2  output  XLEN  read data (combinational).
- w_pend1, w_pend2  output  1  pending status of w_rr1 / w_rr2.
- w_wr  input  AW  write index.
- w_we  input  1  write enable.
- w_wdata  input  XLEN  write data.
- w_iss_en  input  1  mark w_iss_rd pending.
- w_iss_rd  input  AW  destination being issued.
- w_ready  output  1  1 when in RUN state.

## Operation
- States: CLEAR, RUN. A 1 on w_rst at any edge forces CLEAR with clear counter = 1 and all pending bits = 0, including mid-CLEAR, which restarts at 1.
- CLEAR:
  - Each cycle writes 0 to r[cnt], then cnt++.
  - The cycle that writes r[NREG-1] transitions to RUN.
  - CLEAR lasts NREG-1 cycles after reset deasserts.
  - w_we and w_iss_en are ignored.
  - w_rdata1/2 = 0, w_pend1/2 = 0, w_ready = 0.
- RUN, write: on posedge with w_we=1 and w_wr≠0, r[w_wr] ← w_wdata and pend[w_wr] ← 0.
- RUN, issue: on posedge with w_iss_en=1 and w_iss_rd≠0, pend[w_iss_rd] ← 1.
- Simultaneous write and issue to the same index: issue wins, so pend = 1 and r is still updated.
- Register 0: reads 0, never pending. Writes and issues to index 0 are dropped.
- Read data:
  - rrX = 0 → 0.
  - Else if BYPASS=1 and w_we=1 and w_wr = rrX → w_wdata.
  - Else r[rrX].
- Pending out:
  - w_pendX = pend[rrX] & ~(BYPASS & w_we & (w_wr = rrX)).
  - A same-cycle issue does not affect w_pendX until the next cycle.
- Writing a register that is not pending is legal: data is updated and pend stays 0.
- Both read ports are independent. rr1 = rr2 returns identical data and pend values.

## Timing
- Reset values:
  - w_ready = 0 from the reset edge until RUN.
  - Pending bits = 0 after the reset edge.
  - All r[i] = 0 once CLEAR completes.
  - w_rdata1/2 = 0 and w_pend1/2 = 0 throughout reset and CLEAR.
- w_ready rises on the edge that writes r[NREG-1] (NREG-1 edges after w_rst falls, for NREG ≥ 2).
- Read latency is 0 cycles (combinational).
- Write-to-read: BYPASS=1 gives the same cycle. BYPASS=0 gives visibility from the cycle after the write edge.
- Issue-to-pend latency is 1 cycle. Write clears pend in the same cycle with BYPASS=1, otherwise after the next edge.
- No input handshake. The upstream stage must hold w_we and w_iss_en low until w_ready=1; inputs asserted earlier are dropped, not queued.

## Test plan
- Reset/clear:
  - Pre-load r[5] = 0xDEADBEEF, then pulse w_rst for 1 cycle.
  - w_ready = 0 for exactly 31 cycles (NREG=32) and then = 1.
  - Reading r[5] then returns 0x00000000.
  - Reassert w_rst at clear cycle 10: the clear restarts and w_ready = 0 for a full 31 more cycles.
- Write/read and bypass:
  - With BYPASS=1, drive w_we=1, w_wr=3, w_wdata=0x12345678 and w_rr1=3 in the same cycle: w_rdata1 = 0x12345678 that cycle.
  - With BYPASS=0, w_rdata1 holds the old value that cycle and reads 0x12345678 the next.
- Register 0: write 0xFFFFFFFF to index 0 and issue index 0; w_rdata1 = 0 and w_pend1 = 0 on every subsequent cycle.
- Scoreboard:
  - Issue rd=7; the next cycle w_pend2 = 1 with w_rr2 = 7.
  - Write r[7] = 0xA5; with BYPASS=1, w_pend2 = 0 and w_rdata2 = 0xA5 the same cycle.
  - Both are cleared and registered after the edge.
- Simultaneous issue and write to index 9: after the edge, pend[9] = 1 and r[9] = new data.
- Ignored inputs during CLEAR: w_we=1, w_wr=4, w_wdata=0x55 and w_iss_en=1, w_iss_rd=4 held during CLEAR; after w_ready=1, r[4] = 0 and w_pend = 0.
- Parameter sweep with XLEN=16, NREG=8:
  - CLEAR lasts 7 cycles.
  - Write r[7] = 0xBEEF, which reads back 0xBEEF.
  - The index wraps correctly at 7.
